// File: rtl/sram_arbiter.sv
// Single-port SRAM arbiter: shares one 1Mx16 async SRAM between a frame writer and a
// template-matcher reader, with write priority, bounded read starvation and bus turnaround.
module sram_arbiter #(
    parameter int MAX_WR_RUN = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_req,
    input  logic [19:0] wr_addr,
    input  logic [15:0] wr_data,
    output logic        wr_gnt,
    input  logic        rd_req,
    input  logic [19:0] rd_addr,
    output logic        rd_gnt,
    output logic        rd_valid,
    output logic [15:0] rd_data,
    input  logic        frame_done,
    input  logic        tm_busy,
    output logic        tm_start,
    output logic [19:0] sram_addr,
    output logic [15:0] sram_dq_o,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_i,
    output logic        sram_we_n,
    output logic        sram_oe_n,
    output logic        sram_ce_n
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, TURN} state_t;

    localparam logic [7:0] RUN_LIMIT = 8'(MAX_WR_RUN);

    state_t      state;
    state_t      state_next;
    logic        active;
    logic [7:0]  run_cnt;
    logic        rd_pend;
    logic        start_pend;
    logic        run_full;

    // A waiting read has watched MAX_WR_RUN writes go by: writes must yield once.
    assign run_full = rd_req && (run_cnt == RUN_LIMIT);

    always_comb begin
        wr_gnt     = 1'b0;
        rd_gnt     = 1'b0;
        state_next = IDLE;
        if (active) begin
            if (wr_req && !run_full) begin
                wr_gnt     = 1'b1;
                state_next = WRITE;
            end else if (rd_req && state != WRITE) begin
                rd_gnt     = 1'b1;
                state_next = READ;
            end else if (rd_req) begin
                state_next = TURN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            active     <= 1'b0;
            run_cnt    <= 8'd0;
            rd_pend    <= 1'b0;
            rd_valid   <= 1'b0;
            rd_data    <= 16'd0;
            start_pend <= 1'b0;
            tm_start   <= 1'b0;
            sram_addr  <= 20'd0;
            sram_dq_o  <= 16'd0;
            sram_dq_oe <= 1'b0;
            sram_we_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_ce_n  <= 1'b1;
        end else begin
            state     <= state_next;
            active    <= 1'b1;
            sram_ce_n <= 1'b0;

            if (wr_gnt) begin
                sram_addr  <= wr_addr;
                sram_dq_o  <= wr_data;
                sram_dq_oe <= 1'b1;
                sram_we_n  <= 1'b0;
                sram_oe_n  <= 1'b1;
            end else if (rd_gnt) begin
                sram_addr  <= rd_addr;
                sram_dq_oe <= 1'b0;
                sram_we_n  <= 1'b1;
                sram_oe_n  <= 1'b0;
            end else begin
                sram_dq_oe <= 1'b0;
                sram_we_n  <= 1'b1;
                sram_oe_n  <= 1'b1;
            end

            // rd_pend marks the cycle the SRAM is driving read data onto DQ.
            rd_pend  <= rd_gnt;
            rd_valid <= rd_pend;
            if (rd_pend) begin
                rd_data <= sram_dq_i;
            end

            if (!rd_req || rd_gnt) begin
                run_cnt <= 8'd0;
            end else if (wr_gnt && run_cnt != RUN_LIMIT) begin
                run_cnt <= run_cnt + 8'd1;
            end

            if ((start_pend || frame_done) && !tm_busy) begin
                tm_start   <= 1'b1;
                start_pend <= 1'b0;
            end else begin
                tm_start <= 1'b0;
                if (frame_done) begin
                    start_pend <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Single-port controller that shares the 1M×16 external SRAM between the camera frame writer (write port) and the template matcher (read port). Schedules one SRAM access per cycle, enforces write-over-read priority with a starvation bound, inserts bus turnaround, and pulses the matcher's start when a frame has been written. Sits between the capture path, `template_match`, and the SRAM pins.

## Interface
- `MAX_WR_RUN`, 8: maximum consecutive write grants while a read is pending (1–255).
- `clk` in 1: system clock; all logic rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `wr_req` in 1: writer has a pending write; `wr_addr`/`wr_data` held stable until granted.
- `wr_addr` in 20: write word address.
- `wr_data` in 16: write data.
- `wr_gnt` out 1: combinational; write accepted this cycle.
- `rd_req` in 1: matcher has a pending read; `rd_addr` held stable until granted.
- `rd_addr` in 20: read word address.
- `rd_gnt` out 1: combinational; read accepted this cycle.
- `rd_valid` out 1: registered; `rd_data` valid, one-cycle pulse per granted read.
- `rd_data` out 16: registered read data.
- `frame_done` in 1: one-cycle pulse; writer has finished a frame.
- `tm_busy` in 1: matcher is running.
- `tm_start` out 1: registered one-cycle start pulse to the matcher.
- `sram_addr` out 20: registered SRAM address.
- `sram_dq_o` out 16: registered write data.
- `sram_dq_oe` out 1: registered tristate enable for DQ.
- `sram_dq_i` in 16: SRAM DQ input.
- `sram_we_n`, `sram_oe_n`, `sram_ce_n` out 1 each: registered active-low strobes.

## Operation
- States: `IDLE` (no access driven), `WRITE` (write driven), `READ` (read driven), `TURN` (bus idle after a write, before a read).
- Decision each cycle, evaluated combinationally from requests and current state:
  - Grant write if `wr_req` and not (`rd_req` and `run_cnt == MAX_WR_RUN`).
  - Otherwise grant read if `rd_req` and the current state is not `WRITE`.
  - If state is `WRITE` and only a read is eligible, go to `TURN`: no grant this cycle.
  - Otherwise no grant; next state `IDLE`.
- At most one of `wr_gnt`/`rd_gnt` high in any cycle.
- `run_cnt` (8 bit):
  - Increments on each write grant while `rd_req` is high.
  - Clears on a read grant, or on any cycle with `rd_req` low.
  - Saturates at `MAX_WR_RUN`.
- Frame sequencing:
  - `frame_done` sets `start_pend`.
  - When `start_pend` is set and `tm_busy` is low, `tm_start` pulses for one cycle and `start_pend` clears.
  - A `frame_done` arriving while `start_pend` is already set is merged (one start only).
- Reset mid-access:
  - The access is abandoned; no `rd_valid` is produced.
  - `start_pend` and `run_cnt` clear.
- Reset values:
  - `sram_we_n=1`, `sram_oe_n=1`, `sram_ce_n=1`, `sram_dq_oe=0`.
  - `sram_addr=0`, `sram_dq_o=0`.
  - `rd_valid=0`, `rd_data=0`, `tm_start=0`.
  - `wr_gnt=0`, `rd_gnt=0`; state `IDLE`.

## Timing
- Write granted in cycle T (`wr_gnt`=1 in T):
  - During T+1: `sram_addr=wr_addr`, `sram_dq_o=wr_data`, `sram_dq_oe=1`, `sram_we_n=0`, `sram_oe_n=1`.
  - The requester presents its next write in T+1; back-to-back writes run one per cycle.
- Read granted in T:
  - During T+1: `sram_addr=rd_addr`, `sram_oe_n=0`, `sram_dq_oe=0`.
  - `rd_data` captures `sram_dq_i` at the end of T+1; `rd_valid=1` during T+2.
  - Fixed latency of 2 cycles; back-to-back reads run one per cycle.
- Write in T followed by a read: the read is granted no earlier than T+2, leaving one idle bus cycle (T+2) with `sram_dq_oe=0` and `sram_oe_n=1`.
- `sram_ce_n` is 0 from the first cycle after reset release onward.
- `frame_done` in T with `tm_busy=0` gives `tm_start=1` in T+1. If `tm_busy` is high, the pulse comes the cycle after `tm_busy` falls.

## Test plan
- Reset then idle: all outputs hold their reset values; after release, `sram_ce_n=0`; with no requests, no grants and `sram_we_n=sram_oe_n=1`.
- Read stream: `rd_req` held for addresses 0x00010–0x00013 with memory preloaded → `rd_gnt` on 4 consecutive cycles, `rd_valid` on 4 consecutive cycles starting 2 cycles after the first grant, data in address order.
- Write priority and starvation: `wr_req` and `rd_req` held continuously with `MAX_WR_RUN=8` → 8 write grants, one `TURN` cycle, 1 read grant, then writes resume; pattern repeats.
- Turnaround: write to 0x00020 (data 0xBEEF) in T, read of 0x00020 requested in T+1 → `rd_gnt` in T+2, `sram_dq_oe=0` from T+2 onward, `rd_data=0xBEEF` with `rd_valid` in T+4.
- Start sequencing: `frame_done` pulsed with `tm_busy=1`, then a second `frame_done`, then `tm_busy` falls in cycle U → exactly one `tm_start` pulse, in U+1.
- Reset mid-read: `rst_n` asserted in the cycle after a read grant → no `rd_valid`, all outputs at reset values immediately (asynchronous).
